// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   32 x N general-purpose register file for the single-cycle datapath.
//   Two combinational read ports, one synchronous write port.
//   Register 0 always reads as zero, and writes to it have no effect.
//   Q1 always shows the contents of register 1. It is a debug tap and is
//   never bypassed.
//
// Configuration macro:
//   WRITE_BYPASS_EN  If defined, a read port whose index matches an
//                    enabled write to a non-zero register returns
//                    Write_Data_i in the same cycle (write-first).
//                    If not defined, reads return the stored contents
//                    (read-old).
//
// Ports:
//   clk                in   rising-edge clock for writes
//   reset              in   asynchronous, active-low; clears every register
//   Reg_Write_i        in   write enable
//   Write_Register_i   in   [4:0] destination index
//   Read_Register_1_i  in   [4:0] read port 1 index
//   Read_Register_2_i  in   [4:0] read port 2 index
//   Write_Data_i       in   [N-1:0] write data, stored unchanged
//   Read_Data_1_o      out  [N-1:0] contents at Read_Register_1_i
//   Read_Data_2_o      out  [N-1:0] contents at Read_Register_2_i
//   Q1                 out  [N-1:0] contents of register 1
// ---------------------------------------------------------------------------
module register_file #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Reg_Write_i,
  input  logic [4:0]   Write_Register_i,
  input  logic [4:0]   Read_Register_1_i,
  input  logic [4:0]   Read_Register_2_i,
  input  logic [N-1:0] Write_Data_i,
  output logic [N-1:0] Read_Data_1_o,
  output logic [N-1:0] Read_Data_2_o,
  output logic [N-1:0] Q1
);

  logic [N-1:0] regs_q [32];
  logic [N-1:0] regs_d [32];
  logic         wr_en;

  // A write is enabled only when Reg_Write_i is high and the index is not
  // zero, so register 0 keeps its reset value of zero.
  assign wr_en = Reg_Write_i && (Write_Register_i != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[Write_Register_i] = Write_Data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    Read_Data_1_o = (Read_Register_1_i == 5'd0) ? '0 : regs_q[Read_Register_1_i];
    Read_Data_2_o = (Read_Register_2_i == 5'd0) ? '0 : regs_q[Read_Register_2_i];
`ifdef WRITE_BYPASS_EN
    // Write-first forwarding. wr_en already excludes index 0.
    if (wr_en && (Write_Register_i == Read_Register_1_i)) begin
      Read_Data_1_o = Write_Data_i;
    end
    if (wr_en && (Write_Register_i == Read_Register_2_i)) begin
      Read_Data_2_o = Write_Data_i;
    end
`endif
  end

  assign Q1 = regs_q[1];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  localparam int unsigned N = 32;

  logic         clk;
  logic         reset;
  logic         we;
  logic [4:0]   wa;
  logic [4:0]   ra1;
  logic [4:0]   ra2;
  logic [N-1:0] wd;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;
  logic [N-1:0] q1;

  int n_checks = 0;
  int n_errors = 0;

  register_file #(.N(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (we),
    .Write_Register_i  (wa),
    .Read_Register_1_i (ra1),
    .Read_Register_2_i (ra2),
    .Write_Data_i      (wd),
    .Read_Data_1_o     (rd1),
    .Read_Data_2_o     (rd2),
    .Q1                (q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain array of register contents.
  // Reset clears it. An enabled write to a non-zero index stores the data.
  logic [N-1:0] model [32];
  initial for (int i = 0; i < 32; i++) model[i] = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
  end

  function automatic logic [N-1:0] expect_read(input logic [4:0] a);
    logic [N-1:0] v;
    v = (a == 5'd0) ? '0 : model[a];
`ifdef WRITE_BYPASS_EN
    if (reset && we && wa != 5'd0 && wa == a) v = wd;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("model_rd1", rd1, expect_read(ra1));
    chk("model_rd2", rd2, expect_read(ra2));
    chk("model_q1", q1, model[1]);
  end

  task automatic wr(input logic [4:0] a, input logic [N-1:0] d);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd_both(input logic [4:0] a, input logic [N-1:0] exp, input string name);
    ra1 = a; ra2 = a;
    #1;
    chk({name, "_p1"}, rd1, exp);
    chk({name, "_p2"}, rd2, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]   idx [5];
    logic [N-1:0] vals [4];
    idx  = '{5'd0, 5'd2, 5'd4, 5'd25, 5'd31};
    vals = '{32'd7, 32'd20, 32'd6, 32'd78};

    reset = 1'b0; we = 1'b0; wa = '0; ra1 = '0; ra2 = '0; wd = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Test 1: after reset, every output reads zero.
    for (int i = 0; i < 5; i++) begin
      rd_both(idx[i], 32'd0, "reset_zero");
      chk("reset_q1", q1, 32'd0);
    end

    // Test 2: write four registers, then read them back on both ports.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) wr(idx[i+1], vals[i]);
    for (int i = 0; i < 4; i++) rd_both(idx[i+1], vals[i], "wr_readback");

    // Test 3: a write to register 0 is ignored.
    wr(5'd0, 32'd3);
    rd_both(5'd0, 32'd0, "reg0_ignored");

    // Test 4: with Reg_Write_i low, the register does not change.
    we = 1'b0; wa = 5'd2; wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    rd_both(5'd2, 32'd7, "we_low");

    // Test 5: Q1 shows register 1 one edge after the write.
    we = 1'b1; wa = 5'd1; wd = 32'h12345678;
    #1 chk("q1_before_edge", q1, 32'd0);
    @(posedge clk); #1;
    we = 1'b0;
    chk("q1_after_edge", q1, 32'h12345678);
    ra1 = 5'd1; ra2 = 5'd31;
    #1;
    chk("q1_rd1", rd1, 32'h12345678);
    chk("q1_rd2", rd2, 32'd78);

    // Test 6: reset asserted between edges clears everything at once.
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_rd1", rd1, 32'd0);
    chk("async_rst_rd2", rd2, 32'd0);
    chk("async_rst_q1", q1, 32'd0);
    // Reset has priority over a write at the same edge.
    we = 1'b1; wa = 5'd5; wd = 32'hA5A5A5A5;
    @(posedge clk); #1;
    we = 1'b0;
    reset = 1'b1;
    rd_both(5'd5, 32'd0, "rst_prio");
    rd_both(5'd31, 32'd0, "rst_discard");

    // Read during a write to register 4.
    @(posedge clk); #1;
    we = 1'b1; wa = 5'd4; wd = 32'd55; ra1 = 5'd4; ra2 = 5'd4;
    #1;
`ifdef WRITE_BYPASS_EN
    chk("bypass_rd1", rd1, 32'd55);
    chk("bypass_rd2", rd2, 32'd55);
`else
    chk("readold_rd1", rd1, 32'd0);
    chk("readold_rd2", rd2, 32'd0);
`endif
    @(posedge clk); #1;
    we = 1'b0;
    chk("after_write_rd1", rd1, 32'd55);
    chk("after_write_q1", q1, 32'd0);

    // Full-width data is stored unchanged, at the top index.
    wr(5'd31, 32'hFFFF_FFFF);
    rd_both(5'd31, 32'hFFFF_FFFF, "full_width");

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
